// File: rtl/sv32_page_walker_pkg.sv
// Shared types for the Sv32 page-table walker: PTE layout, walk states and the
// TLB update word packing used by cva6_tlb_sv32.
package sv32_ptw_pkg;

  localparam int UPDATE_W      = 63;
  localparam int UPD_VALID_BIT = 62;
  localparam int UPD_IS4M_BIT  = 61;
  localparam int UPD_VPN_LSB   = 41;
  localparam int UPD_ASID_LSB  = 32;
  localparam int UPD_PTE_LSB   = 0;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_WAIT,
    ST_L0_REQ,
    ST_L0_WAIT,
    ST_DONE,
    ST_FAULT,
    ST_ABORT
  } walk_state_e;

  function automatic logic [UPDATE_W-1:0] pack_tlb_update(input logic       is_4m,
                                                          input logic [19:0] vpn,
                                                          input logic [8:0]  asid,
                                                          input pte_t        pte);
    return {1'b1, is_4m, vpn, asid, pte};
  endfunction

endpackage

// File: rtl/sv32_page_walker_if.sv
// Miss request channel and PTE read port of the Sv32 walker.
// Handshakes: a miss transfers on a rising edge where miss_valid_i & miss_ready_o;
// a PTE read is accepted where mem_req_o & mem_gnt_i, and its data returns on a
// later mem_rvalid_i pulse (exactly one per grant, no ready on the return path).
interface sv32_page_walker_if #(
  parameter int ASID_WIDTH = 1
);
  logic                  miss_valid_i;
  logic                  miss_ready_o;
  logic [31:0]           miss_vaddr_i;
  logic [ASID_WIDTH-1:0] miss_asid_i;
  logic                  mem_req_o;
  logic [33:0]           mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  miss_valid_i, miss_vaddr_i, miss_asid_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output miss_ready_o, mem_req_o, mem_addr_o
  );

  modport master (
    output miss_valid_i, miss_vaddr_i, miss_asid_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  miss_ready_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/sv32_page_walker_pte_check.sv
// Combinational Sv32 PTE classification for one walk level.
module sv32_pte_check
  import sv32_ptw_pkg::*;
(
  input  pte_t pte_i,
  input  logic level1_i,
  output logic fault_o,
  output logic leaf_o,
  output logic is_4m_o
);

  // Permission/software bits travel raw into the TLB and play no part here.
  logic unused_bits;
  assign unused_bits = ^{pte_i.ppn1, pte_i.rsw, pte_i.d, pte_i.a, pte_i.g, pte_i.u};

  always_comb begin
    leaf_o  = pte_i.r | pte_i.x;
    is_4m_o = level1_i & leaf_o;
    fault_o = !pte_i.v
            | (!pte_i.r & pte_i.w)
            | (is_4m_o & (pte_i.ppn0 != '0))
            | (!level1_i & !leaf_o);
  end

endmodule

// File: rtl/sv32_page_walker.sv
// Sv32 two-level hardware page-table walker feeding cva6_tlb_sv32 update_i.
// One outstanding PTE read at a time; flush aborts and silently drains a walk.
module sv32_page_walker
  import sv32_ptw_pkg::*;
#(
  parameter int ASID_WIDTH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [21:0]         satp_ppn_i,
  sv32_page_walker_if.slave   bus,
  output logic [UPDATE_W-1:0] update_o,
  output logic                page_fault_o,
  output logic                busy_o,
  output walk_state_e         state_o
);

  walk_state_e           state_q, state_d;
  logic [19:0]           vpn_q;
  logic [8:0]            asid_q;
  logic [21:0]           satp_q;
  pte_t                  pte_q;
  logic                  is_4m_q;
  logic [ASID_WIDTH-1:0] asid_in;
  logic                  level1, chk_fault, chk_leaf, chk_is_4m;
  logic                  accept, pte_arrives;

  logic unused_vaddr;
  assign unused_vaddr = ^bus.miss_vaddr_i[11:0];

  assign asid_in     = bus.miss_asid_i;
  assign level1      = (state_q == ST_L1_WAIT);
  assign accept      = (state_q == ST_IDLE) && bus.miss_valid_i;
  assign pte_arrives = ((state_q == ST_L1_WAIT) || (state_q == ST_L0_WAIT)) && bus.mem_rvalid_i;

  sv32_pte_check u_pte_check (
    .pte_i    (pte_t'(bus.mem_rdata_i)),
    .level1_i (level1),
    .fault_o  (chk_fault),
    .leaf_o   (chk_leaf),
    .is_4m_o  (chk_is_4m)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.miss_valid_i) state_d = ST_L1_REQ;
      ST_L1_REQ, ST_L0_REQ: begin
        // A granted read must still be drained even if the walk is abandoned.
        if (flush_i)            state_d = bus.mem_gnt_i ? ST_ABORT : ST_IDLE;
        else if (bus.mem_gnt_i) state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
      end
      ST_L1_WAIT, ST_L0_WAIT: begin
        if (flush_i)               state_d = bus.mem_rvalid_i ? ST_IDLE : ST_ABORT;
        else if (bus.mem_rvalid_i) begin
          if (chk_fault)     state_d = ST_FAULT;
          else if (chk_leaf) state_d = ST_DONE;
          else               state_d = ST_L0_REQ;
        end
      end
      ST_DONE, ST_FAULT: state_d = ST_IDLE;
      ST_ABORT: if (bus.mem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vpn_q   <= '0;
      asid_q  <= '0;
      satp_q  <= '0;
      pte_q   <= '0;
      is_4m_q <= 1'b0;
    end else begin
      if (accept) begin
        vpn_q  <= bus.miss_vaddr_i[31:12];
        asid_q <= 9'(asid_in);
        satp_q <= satp_ppn_i;
      end
      if (pte_arrives) begin
        pte_q   <= pte_t'(bus.mem_rdata_i);
        is_4m_q <= chk_is_4m;
      end
    end
  end

  always_comb begin
    bus.miss_ready_o = (state_q == ST_IDLE);
    bus.mem_req_o    = (state_q == ST_L1_REQ) || (state_q == ST_L0_REQ);
    bus.mem_addr_o   = '0;
    if (state_q == ST_L1_REQ) bus.mem_addr_o = {satp_q, vpn_q[19:10], 2'b00};
    if (state_q == ST_L0_REQ) bus.mem_addr_o = {pte_q.ppn1, pte_q.ppn0, vpn_q[9:0], 2'b00};
    busy_o       = (state_q != ST_IDLE);
    update_o     = '0;
    if ((state_q == ST_DONE) && !flush_i) update_o = pack_tlb_update(is_4m_q, vpn_q, asid_q, pte_q);
    page_fault_o = (state_q == ST_FAULT) && !flush_i;
    state_o      = state_q;
  end

endmodule

// File: tb/tb_sv32_page_walker.sv
// Directed bench for sv32_page_walker: hand-computed walks, faults, flush, back-pressure, reset.
module tb_sv32_page_walker;
  import sv32_ptw_pkg::*;

  localparam int ASID_WIDTH = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [21:0] satp;
  logic [62:0] update;
  logic        page_fault;
  logic        busy;
  walk_state_e state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [62:0] exp_q[$];

  sv32_page_walker_if #(.ASID_WIDTH(ASID_WIDTH)) bus ();

  sv32_page_walker #(.ASID_WIDTH(ASID_WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .satp_ppn_i   (satp),
    .bus          (bus),
    .update_o     (update),
    .page_fault_o (page_fault),
    .busy_o       (busy),
    .state_o      (state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver tasks ----
  task automatic drive_idle();
    bus.miss_valid_i = 1'b0;
    bus.miss_vaddr_i = '0;
    bus.miss_asid_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    flush            = 1'b0;
  endtask

  // Presents one miss and plays memory (extra gnt / rvalid wait cycles) until a result pulse.
  task automatic do_walk(input logic [31:0] vaddr, input logic [31:0] pte1, input logic [31:0] pte0,
                         input int gnt_extra, input int rv_extra, input bit hold_miss,
                         output logic [62:0] upd, output logic flt, output int lat,
                         output logic [33:0] addr1, output logic [33:0] addr0,
                         output int ngnt, output int glitches);
    int          req_wait, rv_cnt, guard;
    logic [33:0] req_addr;
    bit          req_seen;
    upd = '0; flt = 1'b0; lat = -1; addr1 = '0; addr0 = '0; ngnt = 0; glitches = 0;
    req_wait = 0; rv_cnt = 0; req_addr = '0; req_seen = 0; guard = 0;
    while (!bus.miss_ready_o && guard < 10) begin @(negedge clk); guard++; end
    bus.miss_valid_i = 1'b1;
    bus.miss_vaddr_i = vaddr;
    bus.miss_asid_i  = '1;
    @(negedge clk);
    bus.miss_valid_i = hold_miss;
    for (int k = 1; k <= 40; k++) begin
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      if (update[62] || page_fault) begin
        upd = update; flt = page_fault; lat = k;
        break;
      end
      if (bus.miss_ready_o) glitches++;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = (ngnt == 1) ? pte1 : pte0;
        end
      end
      if (bus.mem_req_o) begin
        if (!req_seen) begin req_seen = 1; req_addr = bus.mem_addr_o; end
        else if (bus.mem_addr_o !== req_addr) glitches++;
        if (req_wait == gnt_extra) begin
          bus.mem_gnt_i = 1'b1;
          ngnt++;
          if (ngnt == 1) addr1 = req_addr; else addr0 = req_addr;
          req_wait = 0; req_seen = 0; rv_cnt = rv_extra + 1;
        end else req_wait++;
      end
      @(negedge clk);
    end
    bus.miss_valid_i = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  // ---- tests ----
  task automatic check_reset_outputs(input string tag);
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s miss_ready got %b want 1", tag, bus.miss_ready_o); end
    n_tests++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL %s mem_req got %b want 0", tag, bus.mem_req_o); end
    n_tests++; if (bus.mem_addr_o !== 34'h0) begin n_fail++; $display("FAIL %s mem_addr got %h want 0", tag, bus.mem_addr_o); end
    n_tests++; if (update !== 63'h0) begin n_fail++; $display("FAIL %s update got %h want 0", tag, update); end
    n_tests++; if (page_fault !== 1'b0) begin n_fail++; $display("FAIL %s page_fault got %b want 0", tag, page_fault); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy got %b want 0", tag, busy); end
  endtask

  task automatic test_reset();
    drive_idle();
    satp = 22'h00010;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_4m_walk();
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    exp_q.push_back({1'b1, 1'b1, 20'h40000, 9'h001, 32'h2000000F});
    do_walk(32'h40000000, 32'h2000000F, 32'h0, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL 4m_latency got %0d want 3", lat); end
    n_tests++; if (a1 !== 34'h10400) begin n_fail++; $display("FAIL 4m_l1_addr got %h want 10400", a1); end
    n_tests++; if (upd !== exp_q.pop_front()) begin n_fail++; $display("FAIL 4m_update got %h", upd); end
    n_tests++; if (flt !== 1'b0 || ngnt !== 1) begin n_fail++; $display("FAIL 4m_fault_or_reads got flt=%b reads=%0d want 0/1", flt, ngnt); end
    @(negedge clk);
    n_tests++; if (update !== 63'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL 4m_pulse_end got update=%h busy=%b want 0/0", update, busy); end
  endtask

  task automatic test_4k_walk();
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    exp_q.push_back({1'b1, 1'b0, 20'h40123, 9'h001, 32'h000800CF});
    do_walk(32'h40123000, 32'h00004001, 32'h000800CF, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL 4k_latency got %0d want 5", lat); end
    n_tests++; if (a1 !== 34'h10400) begin n_fail++; $display("FAIL 4k_l1_addr got %h want 10400", a1); end
    n_tests++; if (a0 !== 34'h1048C) begin n_fail++; $display("FAIL 4k_l0_addr got %h want 1048c", a0); end
    n_tests++; if (upd !== exp_q.pop_front()) begin n_fail++; $display("FAIL 4k_update got %h", upd); end
    n_tests++; if (flt !== 1'b0 || ngnt !== 2) begin n_fail++; $display("FAIL 4k_fault_or_reads got flt=%b reads=%0d want 0/2", flt, ngnt); end
    @(negedge clk);
  endtask

  task automatic test_faults();
    logic [31:0] p1 [4] = '{32'h00000000, 32'h00000405, 32'h00004001, 32'h00000005};
    int          el [4] = '{3, 3, 5, 3};
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    for (int i = 0; i < 4; i++) begin
      do_walk(32'h40000000, p1[i], 32'h00004001, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
      n_tests++; if (flt !== 1'b1 || upd[62] !== 1'b0) begin n_fail++; $display("FAIL fault%0d got flt=%b valid=%b want 1/0", i, flt, upd[62]); end
      n_tests++; if (lat !== el[i]) begin n_fail++; $display("FAIL fault%0d_latency got %0d want %0d", i, lat, el[i]); end
      @(negedge clk);
      n_tests++; if (page_fault !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fault%0d_end got pf=%b busy=%b want 0/0", i, page_fault, busy); end
    end
  endtask

  task automatic test_flush_abort();
    int pulses = 0;
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    bus.miss_valid_i = 1'b1; bus.miss_vaddr_i = 32'h40000000; bus.miss_asid_i = '1;
    @(negedge clk);                                  // L1_REQ
    bus.miss_valid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);                                  // L1_WAIT
    bus.mem_gnt_i = 1'b0; flush = 1'b1;
    @(negedge clk);                                  // ABORT
    flush = 1'b0;
    pulses += int'(update[62]) + int'(page_fault);
    n_tests++; if (busy !== 1'b1 || bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL abort_hold got busy=%b req=%b want 1/0", busy, bus.mem_req_o); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h2000000F;
    n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL abort_ready_early got %b want 0", bus.miss_ready_o); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after got %b want 1", bus.miss_ready_o); end
    for (int k = 0; k < 3; k++) begin
      pulses += int'(update[62]) + int'(page_fault);
      @(negedge clk);
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_silent got %0d pulses want 0", pulses); end
    exp_q.push_back({1'b1, 1'b1, 20'h80000, 9'h001, 32'h1000000F});
    do_walk(32'h80000000, 32'h1000000F, 32'h0, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (upd !== exp_q.pop_front() || lat !== 3 || a1 !== 34'h10800) begin n_fail++; $display("FAIL abort_recover got upd=%h lat=%0d addr=%h", upd, lat, a1); end
    @(negedge clk);
  endtask

  task automatic test_flush_req();
    bus.miss_valid_i = 1'b1; bus.miss_vaddr_i = 32'h40000000; bus.miss_asid_i = '1;
    @(negedge clk);                                  // L1_REQ, no grant
    bus.miss_valid_i = 1'b0; flush = 1'b1;
    n_tests++; if (bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_req_pre got req=%b want 1", bus.mem_req_o); end
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b1 || bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_req_drop got ready=%b req=%b want 1/0", bus.miss_ready_o, bus.mem_req_o); end
    bus.miss_valid_i = 1'b1;                         // flush still high in IDLE
    @(negedge clk);
    bus.miss_valid_i = 1'b0;
    n_tests++; if (busy !== 1'b1 || bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accept got busy=%b req=%b want 1/1", busy, bus.mem_req_o); end
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_req_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_pressure();
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    exp_q.push_back({1'b1, 1'b1, 20'h40000, 9'h001, 32'h2000000F});
    do_walk(32'h40000000, 32'h2000000F, 32'h0, 3, 2, 1, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL bp_latency got %0d want 8", lat); end
    n_tests++; if (gl !== 0) begin n_fail++; $display("FAIL bp_stability got %0d glitches want 0", gl); end
    n_tests++; if (upd !== exp_q.pop_front() || ngnt !== 1) begin n_fail++; $display("FAIL bp_update got %h reads=%0d", upd, ngnt); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_reaccept got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    exp_q.push_back({1'b1, 1'b1, 20'h40000, 9'h001, 32'h2000000F});
    exp_q.push_back({1'b1, 1'b0, 20'h40123, 9'h001, 32'h000800CF});
    do_walk(32'h40000000, 32'h2000000F, 32'h0, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (upd !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_first got %h", upd); end
    do_walk(32'h40123000, 32'h00004001, 32'h000800CF, 1, 1, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (upd !== exp_q.pop_front() || lat !== 9) begin n_fail++; $display("FAIL b2b_second got %h lat=%0d want lat 9", upd, lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    logic [62:0] upd; logic flt; int lat, ngnt, gl; logic [33:0] a1, a0;
    bus.miss_valid_i = 1'b1; bus.miss_vaddr_i = 32'h40123000; bus.miss_asid_i = '1;
    @(negedge clk);
    bus.miss_valid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h00004001;
    @(negedge clk);                                  // L0_REQ
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);                                  // L0_WAIT
    bus.mem_gnt_i = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got busy=%b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h000800CF;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    check_reset_outputs("rst_late_rvalid");
    exp_q.push_back({1'b1, 1'b0, 20'h40123, 9'h001, 32'h000800CF});
    do_walk(32'h40123000, 32'h00004001, 32'h000800CF, 0, 0, 0, upd, flt, lat, a1, a0, ngnt, gl);
    n_tests++; if (upd !== exp_q.pop_front() || lat !== 5) begin n_fail++; $display("FAIL rst_recover got %h lat=%0d", upd, lat); end
    @(negedge clk);
  endtask

  // ---- sequence and report ----
  initial begin
    rst = 1'b1;
    drive_idle();
    satp = 22'h00010;
    test_reset();
    test_4m_walk();
    test_4k_walk();
    test_faults();
    test_flush_abort();
    test_flush_req();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_walk();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
